rate_tick_gen: RTL and testbench
================================

# rate_tick_gen

Consumer side of the speed-control path: takes the 32-bit period word driven by the speed controller and turns it into a one-cycle sample strobe plus a sample address that walks forward or backward through playback memory. It sits between the speed controller and the memory/audio reader. A new period value takes effect only at a tick boundary, so speed changes never produce a short or long glitch period.

## Interface
Parameters:
- ADDR_W, 23, width of the sample address.
- MIN_PERIOD, 2, smallest accepted period; smaller inputs are clamped up to this value.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- period_in  in  32  requested tick period in clk cycles, from the speed controller.
- start  in  1  level; run or resume.
- pause  in  1  level; freeze counter and address.
- restart  in  1  pulse; rewind the address to its start point.
- dir  in  1  0 = forward (address increments), 1 = reverse (address decrements).
- tick  out  1  one-cycle sample strobe.
- addr  out  ADDR_W  current sample address.
- running  out  1  high while state is RUN.
- wrapped  out  1  one-cycle pulse when addr wraps.

## Operation
- FSM states: IDLE, RUN, PAUSED. Reset puts the block in IDLE.
- Reset values:
  - tick = 0, wrapped = 0, running = 0, addr = 0.
  - Cycle counter cnt = 0.
  - Latched period period_q = 32'h132.
- Input priority, highest first: restart, then pause, then start.
- IDLE:
  - start: go to RUN, clear cnt, load period_q with clamp(period_in).
  - Otherwise stay in IDLE.
- RUN:
  - pause: go to PAUSED and freeze cnt.
  - Otherwise cnt increments each cycle.
  - When cnt == period_q-1:
    - cnt goes to 0.
    - period_q reloads with clamp(period_in).
    - tick is asserted on the next cycle.
    - addr steps once.
- PAUSED:
  - start with pause low: return to RUN. cnt resumes from its held value.
  - period_q is not reloaded on resume.
- restart, in any state:
  - cnt goes to 0.
  - addr goes to 0 if dir=0, or to 2^ADDR_W-1 if dir=1.
  - The state does not change, and no tick is issued in that cycle.
- clamp(p) is MIN_PERIOD when p < MIN_PERIOD, otherwise p. The comparison is unsigned, 32-bit.
- Address stepping:
  - Forward: addr+1. From 2^ADDR_W-1 it goes to 0 and pulses wrapped.
  - Reverse: addr-1. From 0 it goes to 2^ADDR_W-1 and pulses wrapped.
- dir is sampled at each step, so a direction change applies from the next step onward.
- period_in changes between ticks have no effect until the next reload.

## Timing
- tick and wrapped are registered. Each is high for exactly one cycle per event.
- addr and tick update on the same clock edge.
- First tick arrives period_q cycles after the edge that accepts start from IDLE.
- In steady RUN, consecutive tick rising edges are exactly period_q cycles apart.
- Pause and tick due in the same cycle: pause wins, the tick is suppressed, and it fires after resume when the count completes.
- Reset asserted mid-run clears all state immediately (asynchronous). Deassertion is seen at the next edge.
- running follows the state register, so it reflects the state one cycle after the accepting edge.

## Configuration
- Macro RATE_TICK_CLKOUT_EN.
  - Defined: adds output clk_out, a 50%-duty square wave at the tick rate. It is high for cnt < period_q/2 (integer division) and low otherwise. It is low in IDLE and holds its level in PAUSED.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package rate_tick_pkg contains:
  - State enum: IDLE, RUN, PAUSED.
  - DEFAULT_PERIOD = 32'h132, shared with the speed controller.
  - The clamp function.
- One sub-module, rate_addr_step. It owns addr and wrapped and takes step, dir, restart, clk and reset.

## Test plan
- Reset, then start with period_in=4 -> tick at cycles 4, 8, 12 after start; addr reads 1, 2, 3.
- Period change while running:
  - RUN at period 10; change period_in to 6 mid-interval -> current interval stays 10 cycles, following intervals are 6 cycles.
- Clamp: period_in=0 or 1 with MIN_PERIOD=2 -> tick every 2 cycles.
- Wrap, with ADDR_W=3:
  - Forward from addr=7 -> addr=0 and a one-cycle wrapped pulse.
  - dir=1 from addr=0 -> addr=7 and a wrapped pulse.
- Pause and resume: pause asserted in the cycle the tick is due -> no tick; the tick fires after start resumes; addr is unchanged while PAUSED.
- restart with dir=1 during RUN -> addr=2^ADDR_W-1, cnt=0, state stays RUN.
- Reset asserted mid-run -> outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/rate_tick_pkg.sv
// Shared definitions for the rate tick generator: FSM states, default period and clamp helper.
package rate_tick_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_e;

  // Power-on period, shared with the speed controller.
  localparam logic [31:0] DEFAULT_PERIOD = 32'h132;

  function automatic logic [31:0] clamp(input logic [31:0] p, input logic [31:0] min_p);
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/rate_tick_gen_if.sv
// Speed-controller to tick-generator bus; clk_out exists only with RATE_TICK_CLKOUT_EN.
interface rate_tick_gen_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [31:0]       period_in;
  logic              start;
  logic              pause;
  logic              restart;
  logic              dir;
  logic              tick;
  logic [ADDR_W-1:0] addr;
  logic              running;
  logic              wrapped;
`ifdef RATE_TICK_CLKOUT_EN
  logic              clk_out;

  modport master (
    output period_in, start, pause, restart, dir,
    input  tick, addr, running, wrapped, clk_out
  );
  modport slave (
    input  period_in, start, pause, restart, dir,
    output tick, addr, running, wrapped, clk_out
  );
`else
  modport master (
    output period_in, start, pause, restart, dir,
    input  tick, addr, running, wrapped
  );
  modport slave (
    input  period_in, start, pause, restart, dir,
    output tick, addr, running, wrapped
  );
`endif
endinterface

// File: rtl/rate_addr_step.sv
// Sample address register: steps forward/backward on request, rewinds on restart, flags wraps.
module rate_addr_step #(
  parameter int unsigned ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_i,
  input  logic              dir_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrapped_o
);

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;

  always_comb begin
    addr_d    = addr_q;
    wrapped_d = 1'b0;
    if (restart_i) begin
      addr_d = dir_i ? AddrMax : '0;
    end else if (step_i) begin
      if (dir_i) begin
        addr_d    = addr_q - AddrOne;
        wrapped_d = (addr_q == '0);
      end else begin
        addr_d    = addr_q + AddrOne;
        wrapped_d = (addr_q == AddrMax);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign addr_o    = addr_q;
  assign wrapped_o = wrapped_q;

endmodule

// File: rtl/rate_tick_gen.sv
// Period-driven sample strobe and address walker; RATE_TICK_CLKOUT_EN adds a tick-rate clk_out.
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter logic [31:0] MIN_PERIOD = 32'd2
) (
  input  logic           clk,
  input  logic           reset,
  rate_tick_gen_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        tick_q, tick_d;
  logic        step;
  logic        due;

  assign due = (cnt_q == period_q - 32'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    step     = 1'b0;
    if (bus.restart) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.pause && bus.start) begin
            state_d  = RUN;
            cnt_d    = '0;
            period_d = clamp(bus.period_in, MIN_PERIOD);
          end
        end
        RUN: begin
          // Pause outranks a due tick; the count stays at period-1 and fires after resume.
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (due) begin
            cnt_d    = '0;
            period_d = clamp(bus.period_in, MIN_PERIOD);
            tick_d   = 1'b1;
            step     = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        PAUSED: begin
          if (!bus.pause && bus.start) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= DEFAULT_PERIOD;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
    end
  end

  rate_addr_step #(
    .ADDR_W(ADDR_W)
  ) u_addr_step (
    .clk      (clk),
    .reset    (reset),
    .step_i   (step),
    .dir_i    (bus.dir),
    .restart_i(bus.restart),
    .addr_o   (bus.addr),
    .wrapped_o(bus.wrapped)
  );

  assign bus.tick    = tick_q;
  assign bus.running = (state_q == RUN);

`ifdef RATE_TICK_CLKOUT_EN
  assign bus.clk_out = (state_q != IDLE) && (cnt_q < (period_q >> 1));
`endif

endmodule

// File: tb/tb_rate_tick_gen.sv
// Self-checking bench for rate_tick_gen: vector table plus tick scoreboard and corner sequences.
module tb_rate_tick_gen;
  import rate_tick_pkg::*;

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] MAXA = '1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rate_tick_gen_if #(.ADDR_W(AW)) bus ();

  rate_tick_gen #(
    .ADDR_W    (AW),
    .MIN_PERIOD(32'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic        wrapped;
  } exp_t;

  typedef struct {
    logic [31:0] period;
    logic        dir;
    int          nticks;
    int          exp_p;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[5];
  int   cyc     = 0;
  int   nchecks = 0;
  int   nerr    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tick monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tick) begin
        if (sb.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_tick: tick=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("tick_cycle", cyc, mon_e.cyc);
          check("tick_addr", 32'(bus.addr), 32'(mon_e.addr));
          check("tick_wrapped", 32'(bus.wrapped), 32'(mon_e.wrapped));
        end
      end else if (bus.wrapped) begin
        nchecks++;
        nerr++;
        $display("FAIL stray_wrapped: wrapped=1 without tick at cycle %0d, required 0", cyc);
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ticks(input int first, input int p, input int n, input logic d,
                            inout logic [AW-1:0] a);
    exp_t e;
    logic [AW-1:0] prev;
    for (int k = 0; k < n; k++) begin
      prev      = a;
      a         = d ? (a - ONE) : (a + ONE);
      e.cyc     = first + k * p;
      e.addr    = a;
      e.wrapped = d ? (prev == '0) : (prev == MAXA);
      sb.push_back(e);
    end
  endtask

  // Asserted away from the clock edge so the checks observe the asynchronous clear.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_wrapped", 32'(bus.wrapped), 32'd0);
    sb.delete();
    tick_clk(1);
    reset = 1'b0;
    tick_clk(1);
  endtask

  task automatic do_start(input logic [31:0] p);
    check("idle_running", 32'(bus.running), 32'd0);
    bus.period_in = p;
    bus.start     = 1'b1;
    tick_clk(1);
    bus.start = 1'b0;
    check("run_running", 32'(bus.running), 32'd1);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    #1;
    nchecks++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: %0d ticks outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int acc;

    bus.period_in = 32'd4;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.restart   = 1'b0;
    bus.dir       = 1'b0;

    vecs[0] = '{32'd4, 1'b0, 3, 4};
    vecs[1] = '{32'd0, 1'b0, 4, 2};
    vecs[2] = '{32'd1, 1'b0, 4, 2};
    vecs[3] = '{32'd5, 1'b1, 3, 5};
    vecs[4] = '{32'd3, 1'b0, 9, 3};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.dir = vecs[i].dir;
      a       = '0;
      acc     = cyc + 1;
      push_ticks(acc + vecs[i].exp_p, vecs[i].exp_p, vecs[i].nticks, vecs[i].dir, a);
      do_start(vecs[i].period);
      drain(vecs[i].nticks * vecs[i].exp_p + 20);
    end

    // Period change mid-interval: current interval keeps 10, later ones use 6.
    do_reset();
    bus.dir = 1'b0;
    a       = '0;
    acc     = cyc + 1;
    push_ticks(acc + 10, 10, 1, 1'b0, a);
    push_ticks(acc + 16, 6, 2, 1'b0, a);
    do_start(32'd10);
    tick_clk(2);
    bus.period_in = 32'd6;
    drain(60);

    // Pause in the cycle the tick is due: tick is deferred until after resume.
    do_reset();
    a   = '0;
    acc = cyc + 1;
    push_ticks(acc + 8, 4, 2, 1'b0, a);
    do_start(32'd4);
    tick_clk(3);
    bus.pause = 1'b1;
    tick_clk(2);
    check("pause_running", 32'(bus.running), 32'd0);
    check("pause_addr", 32'(bus.addr), 32'd0);
    tick_clk(1);
    bus.pause = 1'b0;
    bus.start = 1'b1;
    tick_clk(1);
    bus.start = 1'b0;
    check("resume_running", 32'(bus.running), 32'd1);
    drain(40);

    // Restart with dir=1 while running: address rewinds to top, count restarts, stays in RUN.
    do_reset();
    bus.dir = 1'b0;
    a       = '0;
    acc     = cyc + 1;
    push_ticks(acc + 4, 4, 1, 1'b0, a);
    do_start(32'd4);
    tick_clk(6);
    bus.restart = 1'b1;
    bus.dir     = 1'b1;
    tick_clk(1);
    bus.restart = 1'b0;
    check("restart_addr", 32'(bus.addr), 32'(MAXA));
    check("restart_running", 32'(bus.running), 32'd1);
    check("restart_tick", 32'(bus.tick), 32'd0);
    a = MAXA;
    push_ticks(acc + 11, 4, 2, 1'b1, a);
    drain(40);

    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
